// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with an optional packet lock so multi-byte messages leave the UART back to back.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 64,
    parameter int ACK_TIMEOUT  = 4,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 locked,
    output logic                 lock_abort,
    output logic                 ack_err
);

    localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
    localparam int ACW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [LCW-1:0]   lock_cnt;
    logic [ACW-1:0]   ack_cnt;
    logic [NUM_REQ-1:0] eligible;
    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   cand;
    logic             grant;

    assign eligible = locked ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;

    // Descending scan so the candidate closest after grant_id is the one kept.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDW'((int'(grant_id) + k) % NUM_REQ);
            if (eligible[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign grant = !reset && (state == ARB) && !tx_busy && win_found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            grant_id   <= IDW'(NUM_REQ - 1);
            locked     <= 1'b0;
            lock_abort <= 1'b0;
            ack_err    <= 1'b0;
            lock_cnt   <= '0;
            ack_cnt    <= '0;
        end else begin
            tx_start   <= 1'b0;
            lock_abort <= 1'b0;
            ack_err    <= 1'b0;
            case (state)
                ARB: begin
                    if (grant) begin
                        tx_data  <= req_data[{win_id, 3'b000} +: 8];
                        grant_id <= win_id;
                        locked   <= ~req_last[win_id];
                        lock_cnt <= '0;
                        ack_cnt  <= '0;
                        tx_start <= 1'b1;
                        state    <= ISSUE;
                    end else if (locked && !req_valid[grant_id]) begin
                        // An idle lock owner must not starve everyone else forever.
                        if (lock_cnt == LCW'(LOCK_TIMEOUT - 1)) begin
                            locked     <= 1'b0;
                            lock_abort <= 1'b1;
                            lock_cnt   <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == ACW'(ACK_TIMEOUT - 1)) begin
                        ack_err <= 1'b1;
                        locked  <= 1'b0;
                        ack_cnt <= '0;
                        state   <= ARB;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the bench plays both the
// byte sources and the UART core (tx_busy).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        locked;
    logic        lock_abort;
    logic        ack_err;

    int tests_run;
    int tests_failed;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .LOCK_TIMEOUT (64),
        .ACK_TIMEOUT  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .locked     (locked),
        .lock_abort (lock_abort),
        .ack_err    (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                                 input logic [3:0] last, input logic busy);
        req_valid = valid;
        req_data  = data;
        req_last  = last;
        tx_busy   = busy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called just after inputs settle in ARB; ends one cycle later in ISSUE.
    task automatic acceptStep(input string tag, input logic [3:0] exp_ready,
                              input logic [1:0] exp_id, input logic [7:0] exp_data,
                              input logic exp_locked);
        checkOutput({tag, "_ready"}, req_ready, exp_ready);
        @(negedge clk); #1;
        checkOutput({tag, "_start"}, tx_start, 1'b1);
        checkOutput({tag, "_data"}, tx_data, exp_data);
        checkOutput({tag, "_grant"}, grant_id, exp_id);
        checkOutput({tag, "_locked"}, locked, exp_locked);
    endtask

    // UART core: busy for busy_cycles negedges after tx_start, then idle.
    task automatic serveFrame(input int busy_cycles, input logic [7:0] exp_data);
        tx_busy = 1'b1;
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge clk); #1;
            checkOutput("frame_no_restart", tx_start, 1'b0);
            checkOutput("frame_ready_low", req_ready, 4'b0000);
            checkOutput("frame_hold_data", tx_data, exp_data);
        end
        tx_busy = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b0);
        repeat (2) @(negedge clk);

        // Reset values, with a pending request that must stay unacknowledged.
        applyStimulus(4'b0001, 32'h0000_0011, 4'b1111, 1'b0);
        #1;
        checkOutput("rst_ready", req_ready, 4'b0000);
        checkOutput("rst_start", tx_start, 1'b0);
        checkOutput("rst_data", tx_data, 8'h00);
        checkOutput("rst_grant", grant_id, 2'd3);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_abort", lock_abort, 1'b0);
        checkOutput("rst_ackerr", ack_err, 1'b0);
        @(negedge clk);
        applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b0);
        reset = 1'b0;

        // Single byte from requester 1; a second byte waits for tx_busy to fall.
        @(negedge clk);
        applyStimulus(4'b0010, 32'h0000_A500, 4'b1111, 1'b0);
        #1;
        acceptStep("t2a", 4'b0010, 2'd1, 8'hA5, 1'b0);
        applyStimulus(4'b0010, 32'h0000_5A00, 4'b1111, 1'b0);
        serveFrame(4, 8'hA5);
        @(negedge clk); #1;
        acceptStep("t2b", 4'b0010, 2'd1, 8'h5A, 1'b0);
        applyStimulus(4'b0000, 32'h0000_5A00, 4'b1111, 1'b0);
        serveFrame(2, 8'h5A);

        // Fresh reset, then all four requesters stay valid: order 0,1,2,3,0.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(4'b1111, 32'h1312_1110, 4'b1111, 1'b0);
        #1;
        for (int k = 0; k < 5; k++) begin
            acceptStep("t3", 4'(1 << (k % 4)), 2'(k % 4), 8'(8'h10 + k % 4), 1'b0);
            serveFrame(3, 8'(8'h10 + k % 4));
            @(negedge clk); #1;
        end

        // Requester 2 sends a 3-byte packet while requester 0 waits.
        applyStimulus(4'b0101, 32'h00B0_00C0, 4'b1011, 1'b0);
        #1;
        acceptStep("t4a", 4'b0100, 2'd2, 8'hB0, 1'b1);
        applyStimulus(4'b0101, 32'h00B1_00C0, 4'b1011, 1'b0);
        serveFrame(2, 8'hB0);
        @(negedge clk); #1;
        acceptStep("t4b", 4'b0100, 2'd2, 8'hB1, 1'b1);
        applyStimulus(4'b0101, 32'h00B2_00C0, 4'b1111, 1'b0);
        serveFrame(2, 8'hB1);
        @(negedge clk); #1;
        acceptStep("t4c", 4'b0100, 2'd2, 8'hB2, 1'b0);
        applyStimulus(4'b0001, 32'h0000_00C0, 4'b1111, 1'b0);
        serveFrame(2, 8'hB2);
        @(negedge clk); #1;
        acceptStep("t4d", 4'b0001, 2'd0, 8'hC0, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b0);
        serveFrame(2, 8'hC0);

        // Requester 1 opens a packet then goes silent; requester 3 waits out the lock.
        @(negedge clk);
        applyStimulus(4'b0010, 32'h0000_E100, 4'b1101, 1'b0);
        #1;
        acceptStep("t5a", 4'b0010, 2'd1, 8'hE1, 1'b1);
        applyStimulus(4'b1000, 32'hF300_0000, 4'b1111, 1'b0);
        serveFrame(2, 8'hE1);
        repeat (63) @(negedge clk);
        @(negedge clk); #1;
        checkOutput("t5_still_locked", locked, 1'b1);
        checkOutput("t5_no_abort_yet", lock_abort, 1'b0);
        checkOutput("t5_masked", req_ready, 4'b0000);
        @(negedge clk); #1;
        checkOutput("t5_abort", lock_abort, 1'b1);
        checkOutput("t5_unlocked", locked, 1'b0);
        acceptStep("t5b", 4'b1000, 2'd3, 8'hF3, 1'b0);
        checkOutput("t5_abort_pulse", lock_abort, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b0);
        serveFrame(2, 8'hF3);

        // UART never acknowledges: ack_err after four WAIT_ACK cycles.
        @(negedge clk);
        applyStimulus(4'b0001, 32'h0000_00D0, 4'b1111, 1'b0);
        #1;
        acceptStep("t6a", 4'b0001, 2'd0, 8'hD0, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checkOutput("t6_no_err", ack_err, 1'b0);
            checkOutput("t6_no_start", tx_start, 1'b0);
        end
        @(negedge clk); #1;
        checkOutput("t6_ack_err", ack_err, 1'b1);
        applyStimulus(4'b0010, 32'h0000_D100, 4'b1111, 1'b0);
        #1;
        acceptStep("t6b", 4'b0010, 2'd1, 8'hD1, 1'b0);
        checkOutput("t6_err_pulse", ack_err, 1'b0);

        // Reset while the frame is in WAIT_DONE.
        applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        applyStimulus(4'b0010, 32'h0000_D200, 4'b1111, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_start", tx_start, 1'b0);
        checkOutput("t6_rst_grant", grant_id, 2'd3);
        checkOutput("t6_rst_data", tx_data, 8'h00);
        checkOutput("t6_rst_ready", req_ready, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t6_post_start", tx_start, 1'b0);
        acceptStep("t6c", 4'b0010, 2'd1, 8'hD2, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b0);
        serveFrame(2, 8'hD2);

        // Reset in the middle of ISSUE kills tx_start without waiting for a clock.
        @(negedge clk);
        applyStimulus(4'b0100, 32'h00C5_0000, 4'b1111, 1'b0);
        #1;
        acceptStep("t1a", 4'b0100, 2'd2, 8'hC5, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("t1_async_start", tx_start, 1'b0);
        checkOutput("t1_async_grant", grant_id, 2'd3);
        checkOutput("t1_async_data", tx_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
